// File: rtl/clb_pkg.sv
// Shared definitions for the CLB decryption controller: state width, default
// round parameters and the controller FSM encoding.
package clb_pkg;

   localparam int unsigned STATE_W = 128;
   localparam int unsigned NR_DEF  = 32;
   localparam int unsigned RW_DEF  = 6;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } fsm_e;

endpackage

// File: rtl/clb_round_cnt.sv
// Round counter for the decryption controller: load, clear, decrement
// (saturating at zero) and a zero flag.
module clb_round_cnt
   import clb_pkg::*;
#(
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic [RW-1:0] load_val,
   input  logic          dec,
   output logic [RW-1:0] cnt,
   output logic          zero
);

   logic [RW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/clb_dec_ctrl.sv
// Iterative decryption controller: owns the 128-bit state and round counter and
// steps an external combinational inverse-round datapath. Optional abort: CLB_DEC_ABORT_EN.
module clb_dec_ctrl
   import clb_pkg::*;
#(
   parameter int unsigned NR = NR_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] ct_in,
   output logic [RW-1:0]      rnd_idx,
   output logic [STATE_W-1:0] dp_state,
   input  logic [STATE_W-1:0] dp_next,
   output logic               dp_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] pt_out,
   output logic               busy
`ifdef CLB_DEC_ABORT_EN
   ,
   input  logic               abort
`endif
);

   fsm_e               fsm_q, fsm_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic               cnt_clr, cnt_load, cnt_dec;
   logic               rnd_zero;

   clb_round_cnt #(
      .RW (RW)
   ) u_round_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (RW'(NR - 1)),
      .dec      (cnt_dec),
      .cnt      (rnd_idx),
      .zero     (rnd_zero)
   );

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (fsm_q)
         StIdle: begin
            if (in_valid) begin
               state_d  = ct_in;
               cnt_load = 1'b1;
               fsm_d    = StRun;
            end
         end
         StRun: begin
            state_d = dp_next;
            if (rnd_zero) begin
               fsm_d = StDone;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StDone: begin
            // State is held so pt_out stays valid until handed off.
            if (out_ready) begin
               fsm_d = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
`ifdef CLB_DEC_ABORT_EN
      // Abort overrides every other transition while a block is in flight.
      if (abort && (fsm_q != StIdle)) begin
         fsm_d    = StIdle;
         state_d  = '0;
         cnt_clr  = 1'b1;
         cnt_load = 1'b0;
         cnt_dec  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= StIdle;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
      end
   end

   assign in_ready  = (fsm_q == StIdle);
   assign out_valid = (fsm_q == StDone);
   assign busy      = (fsm_q != StIdle);
   assign dp_last   = (fsm_q == StRun) && rnd_zero;
   assign dp_state  = state_q;
   assign pt_out    = state_q;

endmodule

// File: tb/tb_clb_dec_ctrl.sv
// Self-checking bench for clb_dec_ctrl: NR=32 main instance plus NR=4 and NR=1
// instances; abort sequence is exercised when CLB_DEC_ABORT_EN is defined.
module tb_clb_dec_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, out_ready;
   logic [127:0] ct_in;
   logic         in_ready, out_valid, dp_last, busy;
   logic [5:0]   rnd_idx;
   logic [127:0] dp_state, dp_next, pt_out;
   int           dp_mode;

   logic         iv2, or2;
   logic [127:0] ct2;
   logic         in_ready4, out_valid4, dp_last4, busy4;
   logic [5:0]   rnd4;
   logic [127:0] dp_state4, dp_next4, pt4;
   logic         in_ready1, out_valid1, dp_last1, busy1;
   logic [5:0]   rnd1;
   logic [127:0] dp_state1, dp_next1, pt1;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef CLB_DEC_ABORT_EN
   logic abort = 1'b0;
   logic abort_idle = 1'b0;
`endif

   always #5 clk = ~clk;

   // External datapath stand-ins: 0 -> +1, 1 -> xor with replicated round nibble,
   // 2 -> rotate-left-by-one xor round-dependent pattern.
   function automatic logic [127:0] dp_fn(input int mode, input logic [127:0] s,
                                          input logic [5:0] r);
      case (mode)
         0:       return s + 128'd1;
         1:       return s ^ {32{r[3:0]}};
         default: return {s[126:0], s[127]} ^ {16{2'b10, r}};
      endcase
   endfunction

   // Plaintext after NR inverse rounds, round index counting NR-1 down to 0.
   function automatic logic [127:0] ref_pt(input logic [127:0] ct, input int mode,
                                           input int nr);
      logic [127:0] s;
      if (mode == 0) return ct + 128'(nr);
      s = ct;
      for (int r = nr - 1; r >= 0; r--) s = dp_fn(mode, s, 6'(r));
      return s;
   endfunction

   assign dp_next  = dp_fn(dp_mode, dp_state, rnd_idx);
   assign dp_next4 = dp_fn(1, dp_state4, rnd4);
   assign dp_next1 = dp_state1 + 128'd1;

   clb_dec_ctrl #(.NR(32), .RW(6)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct_in     (ct_in),
      .rnd_idx   (rnd_idx),
      .dp_state  (dp_state),
      .dp_next   (dp_next),
      .dp_last   (dp_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt_out    (pt_out),
      .busy      (busy)
`ifdef CLB_DEC_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   clb_dec_ctrl #(.NR(4), .RW(6)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv2),
      .in_ready  (in_ready4),
      .ct_in     (ct2),
      .rnd_idx   (rnd4),
      .dp_state  (dp_state4),
      .dp_next   (dp_next4),
      .dp_last   (dp_last4),
      .out_valid (out_valid4),
      .out_ready (or2),
      .pt_out    (pt4),
      .busy      (busy4)
`ifdef CLB_DEC_ABORT_EN
      ,
      .abort     (abort_idle)
`endif
   );

   clb_dec_ctrl #(.NR(1), .RW(6)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv2),
      .in_ready  (in_ready1),
      .ct_in     (ct2),
      .rnd_idx   (rnd1),
      .dp_state  (dp_state1),
      .dp_next   (dp_next1),
      .dp_last   (dp_last1),
      .out_valid (out_valid1),
      .out_ready (or2),
      .pt_out    (pt1),
      .busy      (busy1)
`ifdef CLB_DEC_ABORT_EN
      ,
      .abort     (abort_idle)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer one block to the NR=32 instance, measure latency, check and drain it.
   task automatic run_block(input string name, input logic [127:0] ct, input int mode,
                            input logic [127:0] exp);
      int   lat;
      logic rdy_bad;
      @(negedge clk);
      dp_mode   = mode;
      in_valid  = 1'b1;
      ct_in     = ct;
      out_ready = 1'b0;
      check({name, "_in_ready"}, 128'(in_ready), 128'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 0;
      rdy_bad  = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 128'(lat), 128'd32);
      check({name, "_pt"}, pt_out, exp);
      check({name, "_ready_low_in_run"}, 128'(rdy_bad), 128'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_back_to_idle"}, 128'({out_valid, in_ready, busy}), 128'b010);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      out_ready = 1'b1;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      out_ready = 1'b0;
      check({name, "_idle"}, 128'(busy), 128'd0);
   endtask

   typedef struct {
      logic [127:0] ct;
      int           mode;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int           acc[$];
      logic [127:0] ct, held, exp4;
      logic         ov_seen;
      int           mode;

      vecs[0] = '{ct: 128'h0, mode: 0, pt: 128'h20};
      vecs[1] = '{ct: {128{1'b1}}, mode: 0, pt: 128'h1f};
      // Every nibble value appears twice over 32 rounds, so the xors cancel.
      vecs[2] = '{ct: 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, mode: 1,
                  pt: 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
      vecs[3] = '{ct: 128'hdead_beef_0000_1111_2222_3333_cafe_f00d, mode: 2, pt: 128'h0};
      vecs[3].pt = ref_pt(vecs[3].ct, 2, 32);

      in_valid  = 1'b0;
      out_ready = 1'b0;
      ct_in     = '0;
      dp_mode   = 0;
      iv2       = 1'b0;
      or2       = 1'b0;
      ct2       = '0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_dp_last", 128'(dp_last), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_rnd_idx", 128'(rnd_idx), 128'd0);
      check("rst_pt_out", pt_out, 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run_block($sformatf("vec%0d", i), vecs[i].ct, vecs[i].mode,
                                            vecs[i].pt);

      for (int i = 0; i < 6; i++) begin
         ct   = {$urandom, $urandom, $urandom, $urandom};
         mode = int'($urandom_range(0, 2));
         run_block($sformatf("rand%0d", i), ct, mode, ref_pt(ct, mode, 32));
      end

      // NR=4 xor datapath and NR=1 accepted on the same edge.
      @(negedge clk);
      iv2 = 1'b1;
      ct2 = 128'h5555_aaaa_0f0f_f0f0_1234_5678_9abc_def0;
      @(negedge clk);
      iv2 = 1'b0;
      check("nr1_dp_last", 128'({busy1, dp_last1, rnd1}), 128'({1'b1, 1'b1, 6'd0}));
      for (int k = 0; k < 4; k++) begin
         check($sformatf("nr4_rnd%0d", k), 128'(rnd4), 128'(3 - k));
         check($sformatf("nr4_last%0d", k), 128'(dp_last4), 128'(k == 3));
         @(negedge clk);
      end
      exp4 = ref_pt(ct2, 1, 4);
      check("nr4_out_valid", 128'(out_valid4), 128'd1);
      check("nr4_pt", pt4, exp4);
      check("nr1_out_valid", 128'({out_valid1, dp_last1}), 128'b10);
      check("nr1_pt", pt1, ct2 + 128'd1);
      or2 = 1'b1;
      @(negedge clk);
      or2 = 1'b0;
      check("small_idle", 128'({in_ready4, busy4, in_ready1, busy1}), 128'b1010);

      // Back-to-back with in_valid and out_ready held high.
      dp_mode   = 0;
      ct_in     = '0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 150 && acc.size() < 3; cyc++) begin
         if (in_ready) acc.push_back(cyc);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b_count", 128'(acc.size()), 128'd3);
      if (acc.size() == 3) begin
         check("b2b_gap0", 128'(acc[1] - acc[0]), 128'd34);
         check("b2b_gap1", 128'(acc[2] - acc[1]), 128'd34);
      end
      wait_idle("b2b");

      // Stall in DONE for five cycles with a competing ciphertext offered.
      @(negedge clk);
      ct_in    = 128'h77;
      in_valid = 1'b1;
      @(negedge clk);
      ct_in = 128'h999;
      for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
      held = pt_out;
      check("stall_pt", held, 128'h97);
      for (int n = 0; n < 5; n++) begin
         check($sformatf("stall_valid%0d", n), 128'(out_valid), 128'd1);
         check($sformatf("stall_hold%0d", n), pt_out, held);
         check($sformatf("stall_ready%0d", n), 128'(in_ready), 128'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_idle("stall");
      check("stall_no_capture", pt_out, 128'h97);

      // Reset pulsed during round 10 of 32.
      @(negedge clk);
      ct_in    = 128'h1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_vals", 128'({in_ready, out_valid, dp_last, busy, rnd_idx}),
            128'({1'b1, 1'b0, 1'b0, 1'b0, 6'd0}));
      check("midrst_pt", pt_out, 128'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      ov_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      check("midrst_no_out", 128'(ov_seen), 128'd0);

      // Acceptance on the first edge after reset release.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      ct_in    = 128'h5;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("first_edge_accept", 128'({busy, rnd_idx}), 128'({1'b1, 6'd31}));
      for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
      check("first_edge_pt", pt_out, 128'h25);
      wait_idle("first_edge");

`ifdef CLB_DEC_ABORT_EN
      @(negedge clk);
      ct_in    = 128'h7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int n = 0; n < 40 && rnd_idx != 6'd5; n++) @(negedge clk);
      check("abort_at5", 128'(rnd_idx), 128'd5);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_idle", 128'({busy, in_ready, out_valid, rnd_idx}), 128'({3'b010, 6'd0}));
      check("abort_state", pt_out, 128'd0);
      run_block("after_abort", 128'h1234, 0, 128'h1254);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
